// File: rtl/ghostchip_pkg.sv
// Shared constants and types for the keypad conditioning path.
// Holds key geometry, the presenter state encoding and the integrator ceiling.
// Also provides the lowest-set-index helper used by the presenter.
package ghostchip_pkg;

  localparam int unsigned KEY_COUNT  = 16;
  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned INTEG_W    = 2;

  localparam logic [INTEG_W-1:0] INTEG_MAX = 2'd3;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } pres_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic key_code_t lowest_set(input logic [KEY_COUNT-1:0] v);
    key_code_t idx;
    idx = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (v[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_integrator.sv
// Single-key conditioner: 2-flop synchroniser, 2-bit saturating integrator, debounced level flop.
// Latency: 2 cycles of sync, then the level moves on the tick where the integrator saturates.
// No backpressure: free-running, updates only when tick_i is high.
module keypad_integrator
  import ghostchip_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic level_next_o
);

  logic               sync1_q, sync2_q;
  logic [INTEG_W-1:0] integ_q, integ_d;
  logic               level_q, level_d;

  // Two-flop synchroniser for the asynchronous switch level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Integrator steps toward the synced level on each tick; level follows only at the rails.
  always_comb begin
    integ_d = integ_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q) begin
        if (integ_q != INTEG_MAX) integ_d = integ_q + 2'd1;
      end else begin
        if (integ_q != '0) integ_d = integ_q - 2'd1;
      end
      if (integ_d == INTEG_MAX) level_d = 1'b1;
      else if (integ_d == '0) level_d = 1'b0;
    end
  end

  // Integrator and debounced level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      integ_q <= '0;
      level_q <= 1'b0;
    end else begin
      integ_q <= integ_d;
      level_q <= level_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;

endmodule

// File: rtl/keypad_debounce.sv
// Debounces the 16-key matrix and presents key events one at a time (lowest index first).
// Latency: press seen on keypad_matrix within 2 + 3*TICK_CYCLES cycles; key_valid one cycle later.
// Backpressure: an event is held on key_valid/key_code until key_ack; other events queue in pending.
// Build option KEYPAD_RELEASE_EVENT_EN: events are raised on debounced release instead of press.
module keypad_debounce
  import ghostchip_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1024,
  parameter int unsigned TICK_W      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] raw_matrix,
  output logic [KEY_COUNT-1:0] keypad_matrix,
  output logic                 key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                 key_ack
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [KEY_COUNT-1:0] level, level_next, evt;
  logic [KEY_COUNT-1:0] pending_q, pending_d, clr;
  pres_state_e          state_q, state_d;
  key_code_t            code_q, code_d;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Free-running sample tick divider.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    keypad_integrator u_integ (
      .clk_i        (clk),
      .rst_ni       (reset),
      .tick_i       (tick),
      .raw_i        (raw_matrix[k]),
      .level_o      (level[k]),
      .level_next_o (level_next[k])
    );
  end

  // Edges are taken from the next level so pending lands on the same edge as keypad_matrix.
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign evt = level & ~level_next;
`else
  assign evt = level_next & ~level;
`endif

  // Presenter: pick the lowest pending key, hold it until acked; a same-cycle set beats the clear.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          code_d  = lowest_set(pending_q);
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (key_ack) begin
          clr[code_q] = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = (pending_q & ~clr) | evt;
  end

  // Presenter state, latched code and pending event register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
    end
  end

  assign keypad_matrix = level;
  assign key_valid     = (state_q == ST_PRESENT);
  assign key_code      = code_q;

endmodule
